// File: rtl/load_issue_unit_pkg.sv
// Shared widths, FIFO entry layout and FSM encoding for the load issue unit.
package load_issue_unit_pkg;
    localparam int TAG_W          = 6;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int TIMEOUT_DEF    = 15;
    localparam int ENTRY_W        = TAG_W + ADDR_W;
    localparam int ENTRY_ADDR_LSB = 0;
    localparam int ENTRY_TAG_LSB  = ADDR_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LATCH = 3'd2,
        REQ   = 3'd3,
        WB    = 3'd4
    } state_t;
endpackage

// File: rtl/load_issue_unit_timeout.sv
// Saturating cycle counter that flags the last allowed wait cycle of a memory request.
module load_timeout_ctr #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CNT_W-1:0] count_r;

    // Count enabled cycles, holding at the limit so a stalled request cannot wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (clear) begin
            count_r <= '0;
        end else if (enable && (count_r != CNT_W'(LIMIT - 1))) begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign expire = enable && (count_r == CNT_W'(LIMIT - 1));
endmodule

// File: rtl/load_issue_unit.sv
// Pops load entries from a FIFO, issues one memory read at a time and hands the
// result (or a timeout error) to the register-file writeback port.
module load_issue_unit #(
    parameter int TAG_W   = load_issue_unit_pkg::TAG_W,
    parameter int ADDR_W  = load_issue_unit_pkg::ADDR_W,
    parameter int DATA_W  = load_issue_unit_pkg::DATA_W,
    parameter int TIMEOUT = load_issue_unit_pkg::TIMEOUT_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fifo_empty,
    input  logic [TAG_W+ADDR_W-1:0] fifo_dout,
    output logic                    fifo_rd,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    wb_valid,
    input  logic                    wb_ready,
    output logic [TAG_W-1:0]        wb_tag,
    output logic [DATA_W-1:0]       wb_data,
    output logic                    wb_err,
    output logic                    busy,
    output logic [15:0]             load_count
);
    import load_issue_unit_pkg::*;

    state_t              state_r;
    state_t              state_s;
    logic                fifo_rd_r;
    logic                mem_req_r;
    logic                wb_valid_r;
    logic                busy_r;
    logic [TAG_W-1:0]    tag_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   data_r;
    logic                err_r;
    logic [15:0]         count_r;
    logic                ctr_enable_s;
    logic                ctr_clear_s;
    logic                expire_s;

    assign ctr_enable_s = (state_r == REQ);
    assign ctr_clear_s  = (state_r != REQ);

    load_timeout_ctr #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (ctr_clear_s),
        .enable (ctr_enable_s),
        .expire (expire_s)
    );

    // Next-state logic; an acknowledge in the final allowed cycle beats the timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty) state_s = POP;
                else             state_s = IDLE;
            end
            POP:   state_s = LATCH;
            LATCH: state_s = REQ;
            REQ: begin
                if (mem_ack || expire_s) state_s = WB;
                else                     state_s = REQ;
            end
            WB: begin
                if (wb_ready) state_s = IDLE;
                else          state_s = WB;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register; control outputs are decoded from the next state so they leave flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            fifo_rd_r  <= 1'b0;
            mem_req_r  <= 1'b0;
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            fifo_rd_r  <= (state_s == POP);
            mem_req_r  <= (state_s == REQ);
            wb_valid_r <= (state_s == WB);
            busy_r     <= (state_s != IDLE);
        end
    end

    // Entry capture (FIFO data lands one cycle after the pop), read result and completion count.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_r   <= '0;
            addr_r  <= '0;
            data_r  <= '0;
            err_r   <= 1'b0;
            count_r <= 16'd0;
        end else begin
            case (state_r)
                LATCH: begin
                    tag_r  <= fifo_dout[ENTRY_TAG_LSB +: TAG_W];
                    addr_r <= fifo_dout[ENTRY_ADDR_LSB +: ADDR_W];
                end
                REQ: begin
                    if (mem_ack) begin
                        data_r <= mem_rdata;
                        err_r  <= 1'b0;
                    end else if (expire_s) begin
                        data_r <= '0;
                        err_r  <= 1'b1;
                    end
                end
                WB: begin
                    if (wb_ready) count_r <= count_r + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign fifo_rd    = fifo_rd_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = addr_r;
    assign wb_valid   = wb_valid_r;
    assign wb_tag     = tag_r;
    assign wb_data    = data_r;
    assign wb_err     = err_r;
    assign busy       = busy_r;
    assign load_count = count_r;
endmodule

// File: tb/tb_load_issue_unit.sv
// Self-checking bench: FIFO/memory/writeback responders plus a queue-based model of expected results.
module tb_load_issue_unit;
    localparam int TAG_W   = 6;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              fifo_empty;
    logic [21:0]       fifo_dout = 22'd0;
    logic              fifo_rd;
    logic              mem_req;
    logic [15:0]       mem_addr;
    logic              mem_ack;
    logic [15:0]       mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [5:0]        wb_tag;
    logic [15:0]       wb_data;
    logic              wb_err;
    logic              busy;
    logic [15:0]       load_count;

    always #5 clk = ~clk;

    load_issue_unit #(
        .TAG_W(TAG_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd(fifo_rd), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_tag(wb_tag),
        .wb_data(wb_data), .wb_err(wb_err), .busy(busy), .load_count(load_count)
    );

    typedef struct {
        logic [5:0]  tag;
        logic [15:0] addr;
        logic [15:0] rdata;
        int          ack_delay;   // REQ cycles before the ack cycle; >= TIMEOUT means never
        int          rdy_delay;   // WB cycles with wb_ready low before acceptance
    } load_t;

    typedef struct {
        logic [5:0]  tag;
        logic [15:0] data;
        logic        err;
        int          req_len;
        int          rdy_delay;
    } wb_t;

    typedef struct {
        load_t       ld;
        logic [15:0] e_data;
        logic        e_err;
        int          e_req_len;
        int          e_wb_len;
        int          e_lat;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Simple FIFO with one-cycle read latency
    logic [21:0] fmem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) begin
            fifo_dout <= fmem[rd_ptr % 256];
            rd_ptr <= rd_ptr + 1;
        end
    end

    load_t req_q[$];
    wb_t   exp_q[$];
    int    rd_cycles[$];
    load_t cur;
    int    cyc = 0;
    int    model_count = 0;
    int    req_len = 0;
    int    wb_wait = 0;
    int    pop_cyc = 0;
    logic  prev_rd = 1'b0;
    int    last_req_len = 0;
    int    last_wb_len = 0;
    int    last_lat = 0;
    logic [5:0]  last_tag = 6'd0;
    logic [15:0] last_data = 16'd0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic wb_t predict(input load_t l);
        wb_t w;
        w.tag = l.tag;
        w.rdy_delay = l.rdy_delay;
        if (l.ack_delay < TIMEOUT) begin
            w.data = l.rdata;
            w.err = 1'b0;
            w.req_len = l.ack_delay + 1;
        end else begin
            w.data = 16'd0;
            w.err = 1'b1;
            w.req_len = TIMEOUT;
        end
        return w;
    endfunction

    task automatic push_load(input load_t l);
        fmem[wr_ptr % 256] = {l.tag, l.addr};
        req_q.push_back(l);
        exp_q.push_back(predict(l));
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy || !fifo_empty) && n < budget) begin
            step();
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Responders and per-cycle monitor, sampled on the falling edge.
    initial begin
        wb_t w;
        mem_ack = 1'b0;
        mem_rdata = 16'd0;
        wb_ready = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            check("load_count", {16'd0, load_count}, 32'(model_count % 65536));
            if (reset) model_count = 0;
            if (fifo_rd) begin
                check("fifo_rd_when_empty", {31'd0, fifo_empty}, 32'd0);
                check("fifo_rd_pulse_width", {31'd0, prev_rd}, 32'd0);
                check("fifo_rd_during_wb", {31'd0, wb_valid}, 32'd0);
                pop_cyc = cyc;
                rd_cycles.push_back(cyc);
            end
            prev_rd = fifo_rd;
            if (fifo_rd || mem_req || wb_valid) check("busy", {31'd0, busy}, 32'd1);

            if (mem_req) begin
                if (req_len == 0) begin
                    if (req_q.size() == 0) check("req_without_load", {31'd0, mem_req}, 32'd0);
                    else cur = req_q.pop_front();
                end
                check("mem_addr", {16'd0, mem_addr}, {16'd0, cur.addr});
                mem_ack = (req_len == cur.ack_delay);
                mem_rdata = mem_ack ? cur.rdata : 16'($urandom);
                req_len++;
            end else begin
                if (req_len != 0) begin
                    last_req_len = req_len;
                    w = predict(cur);
                    if (!reset) check("mem_req_cycles", 32'(req_len), 32'(w.req_len));
                end
                req_len = 0;
                mem_ack = 1'($urandom_range(0, 1));
                mem_rdata = 16'($urandom);
            end

            if (wb_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", {31'd0, wb_valid}, 32'd0);
                    wb_ready = 1'b1;
                end else begin
                    if (wb_wait == 0) last_lat = cyc - pop_cyc;
                    check("wb_tag", {26'd0, wb_tag}, {26'd0, exp_q[0].tag});
                    check("wb_data", {16'd0, wb_data}, {16'd0, exp_q[0].data});
                    check("wb_err", {31'd0, wb_err}, {31'd0, exp_q[0].err});
                    wb_ready = (wb_wait >= exp_q[0].rdy_delay);
                    wb_wait++;
                    if (wb_ready) begin
                        last_tag = wb_tag;
                        last_data = wb_data;
                        last_err = wb_err;
                        last_wb_len = wb_wait;
                        void'(exp_q.pop_front());
                        model_count++;
                    end
                end
            end else begin
                wb_wait = 0;
                wb_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    function automatic load_t rand_load();
        load_t l;
        int sel;
        l.tag = 6'($urandom);
        l.addr = 16'($urandom);
        l.rdata = 16'($urandom);
        sel = int'($urandom_range(0, 9));
        if (sel < 6)      l.ack_delay = int'($urandom_range(0, 3));
        else if (sel < 8) l.ack_delay = int'($urandom_range(4, 14));
        else              l.ack_delay = 99;
        l.rdy_delay = int'($urandom_range(0, 4));
        return l;
    endfunction

    initial begin
        vec_t vecs [6];
        load_t l;
        int n;
        int k;
        int pushed;

        vecs[0] = '{'{6'h05, 16'h1234, 16'hBEEF, 0, 0},  16'hBEEF, 1'b0, 1, 1, 3};
        vecs[1] = '{'{6'h2A, 16'hABCD, 16'h1357, 3, 0},  16'h1357, 1'b0, 4, 1, 6};
        vecs[2] = '{'{6'h3F, 16'hFFFF, 16'h8001, 99, 0}, 16'h0000, 1'b1, 15, 1, 17};
        vecs[3] = '{'{6'h00, 16'h0000, 16'hFFFF, 0, 5},  16'hFFFF, 1'b0, 1, 6, 3};
        vecs[4] = '{'{6'h11, 16'h0F0F, 16'hCAFE, 14, 2}, 16'hCAFE, 1'b0, 15, 3, 17};
        vecs[5] = '{'{6'h22, 16'h8000, 16'h1111, 13, 0}, 16'h1111, 1'b0, 14, 1, 16};

        reset = 1'b1;
        repeat (3) step();
        check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_wb_err", {31'd0, wb_err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_wb_tag", {26'd0, wb_tag}, 32'd0);
        check("rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("rst_load_count", {16'd0, load_count}, 32'd0);
        reset = 1'b0;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            push_load(vecs[i].ld);
            wait_drain($sformatf("vec%0d_complete", i), 200);
            check($sformatf("vec%0d_tag", i), {26'd0, last_tag}, {26'd0, vecs[i].ld.tag});
            check($sformatf("vec%0d_data", i), {16'd0, last_data}, {16'd0, vecs[i].e_data});
            check($sformatf("vec%0d_err", i), {31'd0, last_err}, {31'd0, vecs[i].e_err});
            check($sformatf("vec%0d_req_cycles", i), 32'(last_req_len), 32'(vecs[i].e_req_len));
            check($sformatf("vec%0d_wb_cycles", i), 32'(last_wb_len), 32'(vecs[i].e_wb_len));
            check($sformatf("vec%0d_pop_to_wb", i), 32'(last_lat), 32'(vecs[i].e_lat));
            check($sformatf("vec%0d_load_count", i), {16'd0, load_count}, 32'(i + 1));
            repeat (2) step();
        end

        // Reset while the request is outstanding discards the entry.
        l = '{6'h15, 16'h4321, 16'h7777, 99, 0};
        push_load(l);
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        check("rstreq_reached_req", {31'd0, mem_req}, 32'd1);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("rstreq_mem_req", {31'd0, mem_req}, 32'd0);
        check("rstreq_busy", {31'd0, busy}, 32'd0);
        check("rstreq_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rstreq_load_count", {16'd0, load_count}, 32'd0);
        check("rstreq_mem_addr", {16'd0, mem_addr}, 32'd0);
        void'(exp_q.pop_front());
        step();
        reset = 1'b0;
        repeat (20) step();
        check("rstreq_no_wb_after", {16'd0, load_count}, 32'd0);

        // Three queued entries issue back to back.
        rd_cycles.delete();
        for (int i = 0; i < 3; i++) begin
            l = '{6'(i + 1), 16'(16'h0100 * (i + 1)), 16'(16'hA000 + i), 0, 0};
            push_load(l);
        end
        wait_drain("b2b_complete", 100);
        check("b2b_pop_count", 32'(rd_cycles.size()), 32'd3);
        if (rd_cycles.size() == 3) begin
            check("b2b_spacing_0", 32'(rd_cycles[1] - rd_cycles[0]), 32'd5);
            check("b2b_spacing_1", 32'(rd_cycles[2] - rd_cycles[1]), 32'd5);
        end
        check("b2b_load_count", {16'd0, load_count}, 32'd3);

        // Randomized bursts against the queue model.
        pushed = 0;
        while (pushed < 40) begin
            k = int'($urandom_range(1, 3));
            for (int j = 0; j < k && pushed < 40; j++) begin
                push_load(rand_load());
                pushed++;
            end
            repeat ($urandom_range(0, 8)) step();
        end
        wait_drain("random_complete", 3000);
        check("random_load_count", {16'd0, load_count}, 32'd43);
        check("random_exp_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
